// File: rtl/xnor_prbs_checker.sv
// Serial PRBS checker for XNOR-feedback LFSR streams.
// Self-syncs in HUNT, free-runs a local reference once LOCKED.
module xnor_prbs_checker #(
  parameter int WIDTH      = 7,
  parameter int TAP_A      = 7,
  parameter int TAP_B      = 6,
  parameter int LOCK_COUNT = 16,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_err,
  output logic             locked,
  output logic             bit_err,
  output logic [ERR_W-1:0] err_count,
  output logic             err_sat
);

  localparam int FW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_nx;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_nx;
  logic [GW-1:0]    good_run;
  logic [GW-1:0]    good_nx;
  logic [BW-1:0]    bad_run;
  logic [BW-1:0]    bad_nx;
  logic [ERR_W-1:0] err_nx;
  logic             p;
  logic             match;
  logic             err_hit;

  assign p      = ~(s[TAP_A-1] ^ s[TAP_B-1]);
  assign match  = ~(p ^ in_bit);
  assign locked = (state == LOCKED);

  // Next-state: sync/lock tracking and reference register update
  always_comb begin
    state_nx = state;
    s_nx     = s;
    fill_nx  = fill;
    good_nx  = good_run;
    bad_nx   = bad_run;
    err_hit  = 1'b0;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          s_nx = {s[WIDTH-2:0], in_bit};
          if (fill < FW'(WIDTH)) begin
            fill_nx = fill + 1'b1;
          end else if (&s) begin
            good_nx = '0;
          end else if (match) begin
            if (good_run == GW'(LOCK_COUNT - 1)) begin
              state_nx = LOCKED;
              good_nx  = '0;
              bad_nx   = '0;
            end else begin
              good_nx = good_run + 1'b1;
            end
          end else begin
            good_nx = '0;
          end
        end
        LOCKED: begin
          s_nx = {s[WIDTH-2:0], p};
          if (match) begin
            bad_nx = '0;
          end else begin
            err_hit = 1'b1;
            if (bad_run == BW'(LOSS_COUNT - 1)) begin
              state_nx = HUNT;
              fill_nx  = '0;
              good_nx  = '0;
              bad_nx   = '0;
            end else begin
              bad_nx = bad_run + 1'b1;
            end
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  // Error counter: clear wins over increment, saturates at all-ones
  always_comb begin
    err_nx = err_count;
    if (clr_err) begin
      err_nx = '0;
    end else if (err_hit && !(&err_count)) begin
      err_nx = err_count + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      s         <= '0;
      fill      <= '0;
      good_run  <= '0;
      bad_run   <= '0;
      bit_err   <= 1'b0;
      err_count <= '0;
      err_sat   <= 1'b0;
    end else begin
      s         <= s_nx;
      fill      <= fill_nx;
      good_run  <= good_nx;
      bad_run   <= bad_nx;
      bit_err   <= err_hit;
      err_count <= err_nx;
      err_sat   <= &err_nx;
    end
  end

endmodule

// File: tb/tb_xnor_prbs_checker.sv
// Scoreboard bench for xnor_prbs_checker.
// Second instance with ERR_W=4 exercises saturation.
module tb_xnor_prbs_checker;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_bit;
  logic        clr_err;
  logic        locked;
  logic        bit_err;
  logic [15:0] err_count;
  logic        err_sat;
  logic        locked4;
  logic        bit_err4;
  logic [3:0]  err_count4;
  logic        err_sat4;

  xnor_prbs_checker dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clr_err   (clr_err),
    .locked    (locked),
    .bit_err   (bit_err),
    .err_count (err_count),
    .err_sat   (err_sat)
  );

  xnor_prbs_checker #(.ERR_W(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .clr_err   (clr_err),
    .locked    (locked4),
    .bit_err   (bit_err4),
    .err_count (err_count4),
    .err_sat   (err_sat4)
  );

  typedef struct {
    logic l;
    logic e;
    int   c;
  } exp_t;

  exp_t     q[$];
  int       checks = 0;
  int       errors = 0;
  bit [6:0] g;
  logic     L;
  int       C;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic nb(input bit inv);
    logic o;
    o = ~(g[6] ^ g[5]);
    g = {g[5:0], o};
    return o ^ inv;
  endfunction

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step(input logic rst, input logic v,
                      input logic b, input logic clr,
                      input logic el, input logic eb,
                      input int ec);
    exp_t x;
    reset    = rst;
    in_valid = v;
    in_bit   = b;
    clr_err  = clr;
    @(posedge clk);
    x.l = el;
    x.e = eb;
    x.c = ec;
    q.push_back(x);
    #1;
  endtask

  task automatic do_reset();
    L = 1'b0;
    C = 0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic clean(input int n, input int lock_at);
    for (int i = 1; i <= n; i++) begin
      if (i == lock_at) L = 1'b1;
      step(1'b0, 1'b1, nb(1'b0), 1'b0, L, 1'b0, C);
    end
  endtask

  task automatic bad(input logic clr);
    C = clr ? 0 : C + 1;
    step(1'b0, 1'b1, nb(1'b1), clr, L, 1'b1, C);
  endtask

  // Monitor: compare every presented cycle against the scoreboard
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("locked", 32'(locked), 32'(x.l));
        chk("bit_err", 32'(bit_err), 32'(x.e));
        chk("err_count", 32'(err_count), 32'(x.c));
        chk("err_sat", 32'(err_sat), 32'(x.c >= 65535));
        chk("locked4", 32'(locked4), 32'(x.l));
        chk("bit_err4", 32'(bit_err4), 32'(x.e));
        chk("err_count4", 32'(err_count4),
            32'(x.c > 15 ? 15 : x.c));
        chk("err_sat4", 32'(err_sat4), 32'(x.c >= 15));
      end
    end
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    clr_err  = 1'b0;
    g        = 7'h00;
    // 1: clean lock after 7 fill + 16 matches
    do_reset();
    clean(23, 23);
    clean(26, 0);
    // 2: single error on bit 50, then idle and clean
    bad(1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, L, 1'b0, C);
    clean(10, 0);
    // 3: four consecutive errors drop lock
    for (int k = 1; k <= 4; k++) begin
      C++;
      if (k == 4) L = 1'b0;
      step(1'b0, 1'b1, nb(1'b1), 1'b0, L, 1'b1, C);
    end
    clean(23, 23);
    clean(5, 0);
    // 5: clear beats increment, then saturate the 4-bit counter
    bad(1'b1);
    clean(2, 0);
    for (int k = 0; k < 20; k++) begin
      bad(1'b0);
      clean(1, 0);
    end
    clean(3, 0);
    // 6: reset while locked overrides valid and clear
    L = 1'b0;
    C = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    clean(23, 23);
    clean(3, 0);
    // 4A: constant ones never lock
    do_reset();
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    end
    // 4B: gapped clean stream locks on 23rd valid bit
    do_reset();
    g = 7'h00;
    for (int i = 1; i <= 30; i++) begin
      if (i == 23) L = 1'b1;
      step(1'b0, 1'b1, nb(1'b0), 1'b0, L, 1'b0, C);
      step(1'b0, 1'b0, 1'b0, 1'b0, L, 1'b0, C);
      step(1'b0, 1'b0, 1'b1, 1'b0, L, 1'b0, C);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xnor_prbs_checker.md
Name: xnor_prbs_checker

Overview:
Serial PRBS checker for bit streams produced by an XNOR-feedback LFSR generator. It sits directly downstream of the XNOR gate stage. The XNOR of two LFSR taps gives the predicted bit, and a second XNOR of predicted versus received bit gives the per-bit match flag. An FSM self-synchronises to the incoming stream, declares lock, then counts bit errors against a free-running local reference.

Parameters:
WIDTH, 7, LFSR length in bits.
TAP_A, 7, first feedback tap (1-based).
TAP_B, 6, second feedback tap (1-based).
LOCK_COUNT, 16, consecutive compared matches needed to enter LOCKED.
LOSS_COUNT, 4, consecutive mismatches in LOCKED that force a return to HUNT.
ERR_W, 16, error counter width.

Ports:
clk  input  1  single clock; all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  in_bit is consumed this cycle.
in_bit  input  1  received serial bit.
clr_err  input  1  synchronous clear of err_count and err_sat.
locked  output  1  high while the FSM is in LOCKED.
bit_err  output  1  one-cycle pulse per mismatched bit while LOCKED.
err_count  output  ERR_W  saturating mismatch count.
err_sat  output  1  high once err_count has reached all-ones.

Behaviour:
- Reset (synchronous, active-high):
  - state=HUNT; shift register s=0; fill, good_run and bad_run = 0.
  - locked=0, bit_err=0, err_count=0, err_sat=0.
- Per-bit definitions:
  - p = ~(s[TAP_A-1] ^ s[TAP_B-1]) is the predicted bit.
  - match = ~(p ^ in_bit).
  - Shift rule: s <= {s[WIDTH-2:0], d}.
- in_valid=0: no state, register or counter change; bit_err=0 on the next cycle.
- HUNT (applies on in_valid=1):
  - d = in_bit, so the register is data-fed.
  - While fill < WIDTH: fill++ and no compare.
  - Once fill == WIDTH, compare each bit:
    - match=1 increments good_run.
    - match=0 clears good_run.
  - Lock-up guard: if s is all-ones, the bit does not count and good_run is cleared.
  - When good_run reaches LOCK_COUNT, transition to LOCKED. locked rises on the cycle after the accepting edge.
  - bit_err and err_count are never affected in HUNT.
- LOCKED (applies on in_valid=1):
  - d = p, so the local reference free-runs; received errors never corrupt s.
  - match=1 clears bad_run.
  - match=0:
    - bad_run++.
    - bit_err=1 on the next cycle.
    - err_count increments and saturates at 2^ERR_W-1; err_sat=1 once that value is reached.
  - When bad_run reaches LOSS_COUNT: go to HUNT with fill, good_run and bad_run = 0, and s retained. locked falls on the next cycle.
  - The mismatch that causes the loss is still counted and still pulses bit_err.
- clr_err:
  - Priority over an increment in the same cycle: err_count=0 and err_sat=0.
  - bit_err still pulses for that mismatch.
  - Does not affect the FSM.
- reset mid-operation overrides everything, including clr_err and in_valid.
- Latency: every output is registered, one cycle after the consuming edge.
- Widths: good_run counts up to LOCK_COUNT; bad_run counts up to LOSS_COUNT. No wrap is permitted.

Test Plan:
1. Clean lock:
   - Stimulus: reset, then a clean PRBS7 generator with g=7'h00, out=~(g[6]^g[5]), g<={g[5:0],out}, driven with in_valid=1 every cycle.
   - Required: locked=1 on the cycle after the 23rd bit (7 fill + 16 matches); err_count=0 throughout.
2. Single error:
   - Stimulus: after lock, invert bit #50.
   - Required: exactly one bit_err pulse; err_count=1; locked stays 1; subsequent clean bits give no errors.
3. Loss of lock:
   - Stimulus: invert 4 consecutive bits.
   - Required: err_count rises by 4; locked falls after the 4th. Resume the clean stream and locked returns after 23 more bits.
4. Lock-up guard and gaps:
   - Stimulus A: 100 bits of constant 1.
   - Required A: locked never rises.
   - Stimulus B: clean stream with in_valid toggling 1,0,0,1…
   - Required B: lock at the 23rd valid bit; idle cycles change nothing.
5. Clear priority and saturation:
   - Stimulus: assert clr_err in the same cycle as a mismatch.
   - Required: err_count=0 and bit_err=1 next cycle.
   - With ERR_W=4, 20 errors give err_count=4'hF and err_sat=1.
6. Reset mid-LOCKED:
   - Stimulus: assert reset for one cycle while locked.
   - Required: next cycle locked=0, bit_err=0, err_count=0; relock after 23 clean bits.
